stack_unwinder: RTL and testbench
=================================

# stack_unwinder

Read-side controller for the LIFO stack: on command, pops entries off the top of a stack until its occupancy falls to a target count, streaming each popped entry downstream over a valid/ready handshake. Used for trail backtracking in the solver core, where a conflict rewinds the trail to a given depth. The downstream consumer is typically an unassign/requeue stage. Drives the stack's `pop` and monitors its `top_data`, `count` and `empty`. While this block is busy, no other agent may push to or pop from the stack.

## Interface
- `WIDTH`, 32: stack entry width.
- `DEPTH`, 32: stack depth. `CNT_W = $clog2(DEPTH)+1` is derived, not overridable.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin an unwind. Sampled only in IDLE.
- `target_count` input CNT_W: stack count to unwind to. Captured on accepted `start`.
- `abort` input 1: synchronous cancel. Returns to IDLE.
- `busy` output 1: high whenever the block is not in IDLE.
- `done` output 1: single-cycle pulse when an unwind completes.
- `popped_count` output CNT_W: number of entries popped in the current or last unwind.
- `stk_pop` output 1: pop strobe to the stack.
- `stk_top_data` input WIDTH: the stack's current top entry.
- `stk_count` input CNT_W: the stack's current occupancy.
- `stk_empty` input 1: stack empty flag.
- `out_valid` output 1: output register holds an entry.
- `out_data` output WIDTH: the popped entry.
- `out_last` output 1: qualifies `out_valid`; marks the final entry of this unwind.
- `out_ready` input 1: downstream accepts the entry this cycle.

## Operation
- States are IDLE, UNWIND and FIN. `busy = (state != IDLE)`. `done = (state == FIN)`.
- IDLE:
  - `start` captures `target_count` into `tgt` and clears `popped_count`.
  - The next state is UNWIND.
- `start` is ignored in UNWIND and FIN.
- Definitions:
  - `remaining = (stk_count > tgt) && !stk_empty`. This uses the live `stk_count`, not a snapshot.
  - `slot_free = !out_valid || out_ready`.
- UNWIND fetch. When `remaining && slot_free`:
  - `stk_pop = 1`.
  - `out_data <= stk_top_data`.
  - `out_valid <= 1`.
  - `out_last <= (stk_count == tgt+1)`.
  - `popped_count <= popped_count+1`.
- `stk_pop` is combinational from the state and these terms. It is never asserted outside UNWIND.
- Output handshake:
  - `out_valid && out_ready` with no fetch in the same cycle clears `out_valid` and `out_last`.
  - While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- UNWIND exit: when `!remaining && (!out_valid || out_ready)`, go to FIN.
- FIN: go to IDLE unconditionally.
- Zero-length unwind (`target_count >= stk_count` at start): no pops and no output beats. `done` still pulses.
- `abort`, in any state:
  - Next state is IDLE.
  - `out_valid` and `out_last` clear.
  - No `done` pulse.
  - `stk_pop` is forced to 0 in the abort cycle.
  - `popped_count` retains its value.
  - Entries already popped but not accepted downstream are discarded.
  - `abort` has priority over `start` and fetch.
- Counter width: `popped_count` never exceeds DEPTH, so it does not wrap.

## Timing
- Reset values: state IDLE; `busy`, `done`, `stk_pop`, `out_valid` and `out_last` are 0; `out_data` and `popped_count` are 0.
- Reset asserted mid-unwind returns immediately to these values. Stack pops already issued stand.
- Latency from `start` (cycle t):
  - First `stk_pop` in cycle t+1.
  - First `out_valid` in cycle t+2.
- Throughput is one entry per cycle with `out_ready` held high.
- The stack updates `count` on the edge of a pop, so the next cycle's `remaining` already reflects it. No bubble.
- `done` is asserted in the cycle after the last beat is accepted, or two cycles after `start` for a zero-length unwind. `busy` falls in the following cycle.
- Backpressure: pops stall while the output register is full and `out_ready` is low. Exactly one entry is buffered.

## Test plan
- Basic unwind:
  - Stimulus: stack holds A..E (E on top, count 5), `target_count=2`, `out_ready=1`, `start` in cycle 0.
  - Required response:
    - `stk_pop` asserted in cycles 1–3.
    - `out_data` is E, D, C in cycles 2–4, with `out_last` set only on C.
    - `done` pulses in cycle 5.
    - `popped_count=3`, and the final stack count is 2.
- Backpressure:
  - Stimulus: same setup as basic unwind, with `out_ready` low in cycles 2–4.
  - Required response:
    - E is held stable on `out_data` through cycle 4.
    - No second pop occurs until cycle 5.
    - Entry order is still E, D, C.
    - `done` pulses exactly once.
- Zero-length unwind:
  - Stimulus: count 3, `target_count=3`, then a separate run with `target_count=7`.
  - Required response: no `stk_pop`, no `out_valid`, `done` in cycle t+2, `popped_count=0`.
- Full drain:
  - Stimulus: DEPTH entries, `target_count=0`.
  - Required response:
    - DEPTH beats in LIFO order, with `out_last` on the bottom entry.
    - `stk_empty` is high afterwards.
    - `popped_count=DEPTH`.
- Abort and start-while-busy:
  - Stimulus: `abort` after 2 pops, with `start` pulsed while busy.
  - Required response:
    - Back in IDLE the next cycle, no `done` pulse, `out_valid` low.
    - The stray `start` is ignored.
    - `popped_count=2`.
- Reset mid-unwind:
  - Stimulus: `rst_n` dropped asynchronously between clock edges during UNWIND.
  - Required response: all outputs reach their reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/stack_unwinder.sv
// Read-side LIFO controller: pops the stack down to a target occupancy and streams
// each popped entry downstream through a single-entry valid/ready output register.
module stack_unwinder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] target_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] popped_count,
    output logic             stk_pop,
    input  logic [WIDTH-1:0] stk_top_data,
    input  logic [CNT_W-1:0] stk_count,
    input  logic             stk_empty,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StUnwind,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   popped_q, popped_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               last_q, last_d;

    logic               remaining;
    logic               slot_free;
    logic               fetch;
    logic [CNT_W:0]     tgt_plus1;

    // Live occupancy, so the pop on this edge is already reflected next cycle.
    assign remaining = (stk_count > tgt_q) && !stk_empty;
    assign slot_free = !valid_q || out_ready;
    assign fetch     = (state_q == StUnwind) && remaining && slot_free && !abort;
    // One extra bit so a target at the counter maximum cannot wrap to zero.
    assign tgt_plus1 = {1'b0, tgt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        popped_d = popped_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        stk_pop  = 1'b0;

        if (fetch) begin
            stk_pop  = 1'b1;
            valid_d  = 1'b1;
            data_d   = stk_top_data;
            last_d   = ({1'b0, stk_count} == tgt_plus1);
            popped_d = popped_q + CNT_W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StUnwind;
                    tgt_d    = target_count;
                    popped_d = '0;
                end
            end
            StUnwind: begin
                if (!remaining && slot_free) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over start and fetch; any buffered entry is dropped.
        if (abort) begin
            state_d  = StIdle;
            tgt_d    = tgt_q;
            popped_d = popped_q;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            data_d   = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tgt_q    <= '0;
            popped_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            popped_q <= popped_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFin);
    assign popped_count = popped_q;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_last     = last_q;

endmodule

// File: tb/tb_stack_unwinder.sv
// Bench for stack_unwinder: behavioural LIFO model, table-driven unwinds with a beat
// scoreboard, plus hand sequences for backpressure, abort and asynchronous reset.
module tb_stack_unwinder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] target_count;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] popped_count;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_top_data;
    logic [CNT_W-1:0] stk_count;
    logic             stk_empty;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    stack_unwinder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .target_count (target_count),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .popped_count (popped_count),
        .stk_pop      (stk_pop),
        .stk_top_data (stk_top_data),
        .stk_count    (stk_count),
        .stk_empty    (stk_empty),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: entry at position i (0 = bottom) is {0x5A0, seed, i}.
    int         cnt = 0;
    logic [7:0] seed = 8'h00;
    logic       load = 1'b0;
    int         load_n = 0;
    logic [7:0] load_seed = 8'h00;

    function automatic logic [31:0] entry(input logic [7:0] s, input int i);
        return {12'h5A0, s, 12'(i)};
    endfunction

    always @(posedge clk) begin
        if (load) begin
            cnt  <= load_n;
            seed <= load_seed;
        end else if (stk_pop && cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign stk_count    = CNT_W'(cnt);
    assign stk_empty    = (cnt == 0);
    assign stk_top_data = (cnt > 0) ? entry(seed, cnt - 1) : '0;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int fill;
        int tgt;
        int ready_mode;  // 0 always ready, 1 random, 2 alternating
        int exp_pops;
    } vec_t;

    beat_t       exp_q[$];
    vec_t        vecs[10];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rel = 0;
    int          done_seen = 0;
    int          done_cyc = -1;
    logic [63:0] pop_mask = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        s_pop, s_valid, s_done, s_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs already driven; sample and score at the falling edge.
    task automatic cyc();
        beat_t b;
        @(negedge clk);
        s_pop   = stk_pop;
        s_valid = out_valid;
        s_done  = done;
        s_busy  = busy;
        if (stk_pop) begin
            if (rel < 64) pop_mask[rel] = 1'b1;
            check("pop_nonempty", 64'(cnt != 0), 64'd1);
        end
        if (stall_prev && out_valid) begin
            check("hold_data", 64'(out_data), 64'(prev_data));
            check("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'(out_data), 64'd0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", 64'(out_data), 64'(b.data));
                check("beat_last", 64'(out_last), 64'(b.last));
            end
        end
        stall_prev = out_valid && !out_ready && !abort;
        prev_data  = out_data;
        prev_last  = out_last;
        if (done) begin
            done_seen++;
            done_cyc = rel;
        end
        rel++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_stack(input int n, input logic [7:0] s);
        load_n    = n;
        load_seed = s;
        load      = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic start_unwind(input int tgt);
        int n;
        n = (cnt > tgt) ? cnt - tgt : 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{last: (k == n - 1), data: entry(seed, cnt - 1 - k)});
        end
        rel          = 0;
        pop_mask     = '0;
        done_seen    = 0;
        done_cyc     = -1;
        start        = 1'b1;
        target_count = CNT_W'(tgt);
        cyc();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pop"}, 64'(stk_pop), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_popped"}, 64'(popped_count), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        target_count = '0;
        out_ready    = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        vecs[0] = '{5, 2, 0, 3};
        vecs[1] = '{3, 3, 0, 0};
        vecs[2] = '{3, 7, 0, 0};
        vecs[3] = '{32, 0, 0, 32};
        vecs[4] = '{6, 1, 1, 5};
        vecs[5] = '{4, 0, 2, 4};
        vecs[6] = '{1, 0, 1, 1};
        vecs[7] = '{0, 0, 0, 0};
        vecs[8] = '{10, 9, 2, 1};
        vecs[9] = '{32, 16, 1, 16};

        for (int i = 0; i < 10; i++) begin
            load_stack(vecs[i].fill, 8'(i + 1));
            out_ready = 1'b1;
            start_unwind(vecs[i].tgt);
            for (int k = 0; k < 400 && done_seen == 0; k++) begin
                case (vecs[i].ready_mode)
                    1: out_ready = 1'($urandom_range(0, 1));
                    2: out_ready = 1'(rel % 2);
                    default: out_ready = 1'b1;
                endcase
                cyc();
            end
            check("vec_done_seen", 64'(done_seen), 64'd1);
            out_ready = 1'b1;
            cyc();
            check("vec_busy_after", 64'(s_busy), 64'd0);
            check("vec_done_once", 64'(done_seen), 64'd1);
            check("vec_popped", 64'(popped_count), 64'(vecs[i].exp_pops));
            check("vec_final_cnt", 64'(cnt), 64'(vecs[i].fill - vecs[i].exp_pops));
            check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
            check("vec_empty_flag", 64'(stk_empty), 64'(vecs[i].fill == vecs[i].exp_pops));
            if (vecs[i].ready_mode == 0) begin
                check("vec_done_cycle", 64'(done_cyc), 64'(vecs[i].exp_pops + 2));
                check("vec_pop_cycles", pop_mask,
                      ((64'd1 << vecs[i].exp_pops) - 64'd1) << 1);
            end
            exp_q.delete();
        end

        // Backpressure: out_ready low in cycles 2..4.
        load_stack(5, 8'hB0);
        out_ready = 1'b1;
        start_unwind(2);
        for (int c = 1; c < 20 && done_seen == 0; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("bp_pop_cycles", pop_mask, 64'h62);
        check("bp_done_cycle", 64'(done_cyc), 64'd8);
        check("bp_done_once", 64'(done_seen), 64'd1);
        check("bp_popped", 64'(popped_count), 64'd3);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Abort after two pops, with stray starts while busy.
        load_stack(6, 8'hC0);
        out_ready = 1'b1;
        start_unwind(0);
        start        = 1'b1;
        target_count = CNT_W'(5);
        cyc();
        start = 1'b0;
        cyc();
        abort = 1'b1;
        start = 1'b1;
        cyc();
        check("abort_pop_forced", 64'(s_pop), 64'd0);
        abort = 1'b0;
        start = 1'b0;
        cyc();
        check("abort_idle", 64'(s_busy), 64'd0);
        check("abort_valid", 64'(s_valid), 64'd0);
        cyc();
        check("abort_stays_idle", 64'(s_busy), 64'd0);
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_pop_cycles", pop_mask, 64'h6);
        check("abort_popped", 64'(popped_count), 64'd2);
        check("abort_stack_cnt", 64'(cnt), 64'd4);
        exp_q.delete();

        // Asynchronous reset between clock edges during UNWIND.
        load_stack(8, 8'hD0);
        out_ready = 1'b1;
        start_unwind(0);
        cyc();
        cyc();
        cyc();
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
        check("midrst_stack_cnt", 64'(cnt), 64'd5);
        cyc();
        check("midrst_idle", 64'(s_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
